// File: rtl/timer_mmio_pkg.sv
// Shared definitions for the Timer MMIO initiator: register offsets, FSM states, strobe selects.
package timer_mmio_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STB_W  = 3;

  localparam logic [ADDR_W-1:0] ADDR_MTIME_L = 5'h00;
  localparam logic [ADDR_W-1:0] ADDR_MTIME_H = 5'h04;
  localparam logic [ADDR_W-1:0] ADDR_CMP_L   = 5'h08;
  localparam logic [ADDR_W-1:0] ADDR_CMP_H   = 5'h0C;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 5'h10;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 5'h14;

  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_GAP, ST_ACK} state_e;

  typedef enum logic [1:0] {SEL_NONE, SEL_EN, SEL_CMP_L, SEL_CMP_H} sel_e;

  // Strobe vector layout: [0]=wr_en, [1]=wr_mtimecmp_in_l, [2]=wr_mtimecmp_in_h
  function automatic logic [STB_W-1:0] sel_onehot(input sel_e sel);
    logic [STB_W-1:0] v;
    v = '0;
    case (sel)
      SEL_EN:    v = 3'b001;
      SEL_CMP_L: v = 3'b010;
      SEL_CMP_H: v = 3'b100;
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/timer_strobe_seq.sv
// Pulse-then-gap sequencer: holds one selected strobe high, then low, flagging the last cycle of each phase.
module timer_strobe_seq
  import timer_mmio_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_start,
  input  sel_e             i_sel,
  output logic [STB_W-1:0] o_strobe,
  output logic             o_done_c
);

  localparam int unsigned MAX_C = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  state_e             r_phase;
  logic [CNT_W-1:0]   r_cnt;
  logic [STB_W-1:0]   r_strobe;

  assign o_strobe = r_strobe;
  // High on the final cycle of the current STROBE or GAP phase
  assign o_done_c = (r_phase != ST_IDLE) && (r_cnt == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_phase  <= ST_IDLE;
      r_cnt    <= '0;
      r_strobe <= '0;
    end else begin
      case (r_phase)
        ST_IDLE: begin
          if (i_start) begin
            r_phase  <= ST_STROBE;
            r_cnt    <= CNT_W'(PULSE_CYCLES - 1);
            r_strobe <= sel_onehot(i_sel);
          end
        end
        ST_STROBE: begin
          if (r_cnt == '0) begin
            r_phase  <= ST_GAP;
            r_cnt    <= CNT_W'(GAP_CYCLES - 1);
            r_strobe <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) r_phase <= ST_IDLE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: begin
          r_phase  <= ST_IDLE;
          r_strobe <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/timer_mmio_ctrl.sv
// CPU-bus initiator for the Timer: register decode, shadows, mtime high snapshot, strobe sequencing.
// Optional sticky interrupt status at 0x14 and irq enable in ctrl[1]: TIMER_MMIO_INT_STATUS_EN.
module timer_mmio_ctrl
  import timer_mmio_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter logic [63:0] CMP_RESET    = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_ack,
  input  logic [DATA_W-1:0] mtime_h,
  input  logic [DATA_W-1:0] mtime_l,
  input  logic              timer_int,
  output logic              en,
  output logic              wr_en,
  output logic              wr_mtimecmp_in_h,
  output logic              wr_mtimecmp_in_l,
  output logic [DATA_W-1:0] mtimecmp_in_h,
  output logic [DATA_W-1:0] mtimecmp_in_l,
  output logic              irq
);

  state_e             r_state;
  logic               r_ack;
  logic [DATA_W-1:0]  r_rdata;
  logic [DATA_W-1:0]  r_cmp_h;
  logic [DATA_W-1:0]  r_cmp_l;
  logic [DATA_W-1:0]  r_hi_snap;
  logic               r_en;
  logic               w_accept;
  logic               w_start;
  logic               w_done_c;
  logic               w_ie;
  sel_e               w_sel;
  logic [DATA_W-1:0]  w_rd_data;
  logic [STB_W-1:0]   w_strobe;

`ifdef TIMER_MMIO_INT_STATUS_EN
  logic r_ie;
  logic r_sts;
  logic w_sts_clr;

  assign w_sts_clr = w_accept && bus_we && (bus_addr == ADDR_STATUS) && bus_wdata[0];
  assign w_ie      = r_ie;
  assign irq       = r_sts & r_ie;

  // Sticky status: a set in the same cycle as a W1C clear wins
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         r_sts <= 1'b0;
    else if (timer_int) r_sts <= 1'b1;
    else if (w_sts_clr) r_sts <= 1'b0;
  end
`else
  assign w_ie = 1'b0;
  assign irq  = timer_int;
`endif

  assign w_accept = (r_state == ST_IDLE) && bus_req;
  assign w_start  = w_accept && (w_sel != SEL_NONE);

  assign bus_ack          = r_ack;
  assign bus_rdata        = r_rdata;
  assign en               = r_en;
  assign mtimecmp_in_h    = r_cmp_h;
  assign mtimecmp_in_l    = r_cmp_l;
  assign wr_en            = w_strobe[0];
  assign wr_mtimecmp_in_l = w_strobe[1];
  assign wr_mtimecmp_in_h = w_strobe[2];

  // Only stores to writable registers launch a strobe sequence
  always_comb begin
    w_sel = SEL_NONE;
    if (bus_we) begin
      case (bus_addr)
        ADDR_CMP_L: w_sel = SEL_CMP_L;
        ADDR_CMP_H: w_sel = SEL_CMP_H;
        ADDR_CTRL:  w_sel = SEL_EN;
        default:    w_sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (bus_addr)
      ADDR_MTIME_L: w_rd_data = mtime_l;
      ADDR_MTIME_H: w_rd_data = r_hi_snap;
      ADDR_CMP_L:   w_rd_data = r_cmp_l;
      ADDR_CMP_H:   w_rd_data = r_cmp_h;
      ADDR_CTRL:    w_rd_data = {30'b0, w_ie, r_en};
`ifdef TIMER_MMIO_INT_STATUS_EN
      ADDR_STATUS:  w_rd_data = {31'b0, r_sts};
`endif
      default:      w_rd_data = '0;
    endcase
  end

  timer_strobe_seq #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_seq (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .i_start  (w_start),
    .i_sel    (w_sel),
    .o_strobe (w_strobe),
    .o_done_c (w_done_c)
  );

  // Shadows settle at the accept edge, ahead of the strobe they qualify
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_ack     <= 1'b0;
      r_rdata   <= '0;
      r_cmp_h   <= CMP_RESET[63:32];
      r_cmp_l   <= CMP_RESET[31:0];
      r_hi_snap <= '0;
      r_en      <= 1'b0;
`ifdef TIMER_MMIO_INT_STATUS_EN
      r_ie      <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rdata <= bus_we ? '0 : w_rd_data;
            if (!bus_we && (bus_addr == ADDR_MTIME_L)) r_hi_snap <= mtime_h;
            case (w_sel)
              SEL_CMP_L: r_cmp_l <= bus_wdata;
              SEL_CMP_H: r_cmp_h <= bus_wdata;
              SEL_EN: begin
                r_en <= bus_wdata[0];
`ifdef TIMER_MMIO_INT_STATUS_EN
                r_ie <= bus_wdata[1];
`endif
              end
              default: ;
            endcase
            if (w_sel != SEL_NONE) begin
              r_state <= ST_STROBE;
            end else begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
            end
          end
        end
        ST_STROBE: if (w_done_c) r_state <= ST_GAP;
        ST_GAP: begin
          if (w_done_c) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
          end
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_mmio_ctrl.sv
// Randomized bench for timer_mmio_ctrl against an address-map reference model and a Timer edge-capture stub.
module tb_timer_mmio_ctrl;

  localparam int unsigned P = 1;
  localparam int unsigned G = 2;
  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [4:0] A_MTL = 5'h00, A_MTH = 5'h04, A_CML = 5'h08, A_CMH = 5'h0C,
                         A_CTL = 5'h10, A_STS = 5'h14;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        bus_req, bus_we, bus_ack;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic [31:0] mtime_h, mtime_l, mtimecmp_in_h, mtimecmp_in_l;
  logic        timer_int, en, wr_en, wr_mtimecmp_in_h, wr_mtimecmp_in_l, irq;

  int n_checks = 0;
  int n_errors = 0;

  timer_mmio_ctrl #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .CMP_RESET(CMP_RST)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .mtime_h(mtime_h), .mtime_l(mtime_l), .timer_int(timer_int), .en(en), .wr_en(wr_en),
    .wr_mtimecmp_in_h(wr_mtimecmp_in_h), .wr_mtimecmp_in_l(wr_mtimecmp_in_l),
    .mtimecmp_in_h(mtimecmp_in_h), .mtimecmp_in_l(mtimecmp_in_l), .irq(irq)
  );

  always #5 CLK = ~CLK;

  // Timer stub: commits on each rising strobe edge
  logic        tm_en, p_en, p_l, p_h;
  logic [63:0] tm_cmp;
  int          tm_commits;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_en <= 1'b0; p_l <= 1'b0; p_h <= 1'b0;
      tm_en <= 1'b0; tm_cmp <= CMP_RST; tm_commits <= 0;
    end else begin
      p_en <= wr_en; p_l <= wr_mtimecmp_in_l; p_h <= wr_mtimecmp_in_h;
      if (wr_en && !p_en) begin tm_en <= en; tm_commits <= tm_commits + 1; end
      if (wr_mtimecmp_in_l && !p_l) begin tm_cmp[31:0] <= mtimecmp_in_l; tm_commits <= tm_commits + 1; end
      if (wr_mtimecmp_in_h && !p_h) begin tm_cmp[63:32] <= mtimecmp_in_h; tm_commits <= tm_commits + 1; end
    end
  end

  // Reference model state
  logic [63:0] m_cmp;
  logic [31:0] m_snap;
  logic        m_en, m_ie, m_sts;

  task automatic m_reset();
    m_cmp = CMP_RST; m_snap = '0; m_en = 1'b0; m_ie = 1'b0; m_sts = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      A_MTL:   return mtime_l;
      A_MTH:   return m_snap;
      A_CML:   return m_cmp[31:0];
      A_CMH:   return m_cmp[63:32];
      A_CTL:   return {30'b0, m_ie, m_en};
`ifdef TIMER_MMIO_INT_STATUS_EN
      A_STS:   return {31'b0, m_sts};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Observations of the most recent bus transfer
  bit          x_got, x_overlap, x_ack_after, x_irq1;
  int          x_lat, x_first;
  int          x_hi[3];
  logic [31:0] x_rdata;

  task automatic bus_xfer(input logic we, input logic [4:0] a, input logic [31:0] wd);
    int cyc;
    int nh;
    bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = wd;
    x_got = 1'b0; x_lat = -1; x_first = -1; x_overlap = 1'b0; x_rdata = '0; x_irq1 = 1'b0;
    for (int k = 0; k < 3; k++) x_hi[k] = 0;
    cyc = 0;
    while (!x_got && cyc < 32) begin
      @(posedge CLK); @(negedge CLK); cyc++;
      if (cyc == 1) x_irq1 = irq;
      nh = int'(wr_en) + int'(wr_mtimecmp_in_l) + int'(wr_mtimecmp_in_h);
      if (nh > 1) x_overlap = 1'b1;
      if (nh > 0 && x_first < 0) x_first = cyc;
      if (wr_en) x_hi[0]++;
      if (wr_mtimecmp_in_l) x_hi[1]++;
      if (wr_mtimecmp_in_h) x_hi[2]++;
      if (bus_ack) begin x_got = 1'b1; x_lat = cyc; x_rdata = bus_rdata; end
    end
    bus_req = 1'b0; bus_we = 1'b0;
    @(negedge CLK);
    x_ack_after = bus_ack | wr_en | wr_mtimecmp_in_l | wr_mtimecmp_in_h;
  endtask

  task automatic txn(input logic we, input logic [4:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    bit          mapped;
    int          exp_lat, c0;
    int          exp_hi[3];
    exp_rd  = we ? 32'h0 : m_read(a);
    mapped  = we && (a == A_CML || a == A_CMH || a == A_CTL);
    exp_lat = mapped ? int'(1 + P + G) : 1;
    exp_hi  = '{0, 0, 0};
    if (mapped) begin
      if (a == A_CTL) exp_hi[0] = int'(P);
      else if (a == A_CML) exp_hi[1] = int'(P);
      else exp_hi[2] = int'(P);
    end
    if (!we && a == A_MTL) m_snap = mtime_h;
    if (we && a == A_CML) m_cmp[31:0] = wd;
    if (we && a == A_CMH) m_cmp[63:32] = wd;
    if (we && a == A_CTL) begin
      m_en = wd[0];
`ifdef TIMER_MMIO_INT_STATUS_EN
      m_ie = wd[1];
`endif
    end
`ifdef TIMER_MMIO_INT_STATUS_EN
    if (we && a == A_STS && wd[0]) m_sts = 1'b0;
    if (timer_int) m_sts = 1'b1;
`endif
    c0 = tm_commits;
    bus_xfer(we, a, wd);
    chk("ack_seen", 64'(x_got), 64'(1));
    chk("ack_latency", 64'(x_lat), 64'(exp_lat));
    chk("rdata", 64'(x_rdata), 64'(exp_rd));
    chk("strobe_overlap", 64'(x_overlap), 64'(0));
    chk("strobe_start", 64'(x_first), mapped ? 64'(1) : 64'(-1));
    chk("wr_en_cycles", 64'(x_hi[0]), 64'(exp_hi[0]));
    chk("wr_cmp_l_cycles", 64'(x_hi[1]), 64'(exp_hi[1]));
    chk("wr_cmp_h_cycles", 64'(x_hi[2]), 64'(exp_hi[2]));
    chk("ack_single", 64'(x_ack_after), 64'(0));
    chk("timer_commits", 64'(tm_commits - c0), mapped ? 64'(1) : 64'(0));
    chk("shadow_cmp", {mtimecmp_in_h, mtimecmp_in_l}, m_cmp);
    chk("shadow_en", 64'(en), 64'(m_en));
    chk("timer_cmp", tm_cmp, m_cmp);
    chk("timer_en", 64'(tm_en), 64'(m_en));
`ifdef TIMER_MMIO_INT_STATUS_EN
    chk("irq", 64'(irq), 64'(m_sts & m_ie));
`else
    chk("irq", 64'(irq), 64'(timer_int));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bit          a_seen;
    logic [4:0]  ra;
    RST_N = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    mtime_h = '0; mtime_l = '0; timer_int = 1'b0;
    m_reset();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_ack", 64'(bus_ack), 64'(0));
    chk("rst_rdata", 64'(bus_rdata), 64'(0));
    chk("rst_en", 64'(en), 64'(0));
    chk("rst_strobes", 64'({wr_en, wr_mtimecmp_in_l, wr_mtimecmp_in_h}), 64'(0));
    chk("rst_cmp", {mtimecmp_in_h, mtimecmp_in_l}, CMP_RST);

    txn(1'b1, A_CML, 32'hDEAD_BEEF);
    chk("deadbeef_timer", 64'(tm_cmp[31:0]), 64'(32'hDEAD_BEEF));

    txn(1'b1, A_CTL, 32'h1);
    chk("en_on_timer", 64'(tm_en), 64'(1));
    txn(1'b1, A_CTL, 32'h0);
    chk("en_off_timer", 64'(tm_en), 64'(0));

    mtime_h = 32'h0000_0001; mtime_l = 32'hFFFF_FFFF;
    txn(1'b0, A_MTL, 32'h0);
    chk("snap_lo", 64'(x_rdata), 64'(32'hFFFF_FFFF));
    mtime_h = 32'h0000_0002;
    txn(1'b0, A_MTH, 32'h0);
    chk("snap_hi", 64'(x_rdata), 64'(32'h0000_0001));

    txn(1'b1, A_MTL, 32'h5555_AAAA);
    txn(1'b0, 5'h18, 32'h0);

    // Reset while the high-word compare strobe is up
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = A_CMH; bus_wdata = 32'h1234_5678;
    @(posedge CLK); @(negedge CLK);
    chk("rst_mid_strobe_high", 64'(wr_mtimecmp_in_h), 64'(1));
    chk("rst_mid_shadow", 64'(mtimecmp_in_h), 64'(32'h1234_5678));
    #1 RST_N = 1'b0;
    #1;
    chk("rst_mid_strobe_drop", 64'(wr_mtimecmp_in_h), 64'(0));
    bus_req = 1'b0; bus_we = 1'b0;
    a_seen = 1'b0;
    repeat (3) begin @(negedge CLK); if (bus_ack) a_seen = 1'b1; end
    chk("rst_mid_no_ack", 64'(a_seen), 64'(0));
    RST_N = 1'b1;
    m_reset();
    @(negedge CLK);
    chk("rst_mid_ack_after", 64'(bus_ack), 64'(0));
    chk("rst_mid_shadow_back", 64'(mtimecmp_in_h), 64'(32'hFFFF_FFFF));
    txn(1'b0, A_CMH, 32'h0);

    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0: ra = A_MTL;
        1: ra = A_MTH;
        2: ra = A_CML;
        3: ra = A_CMH;
        4: ra = A_CTL;
        5: ra = A_STS;
        6: ra = 5'h18;
        7: ra = 5'h1C;
        default: ra = 5'($urandom_range(0, 31));
      endcase
      mtime_h   = $urandom;
      mtime_l   = $urandom;
      timer_int = ($urandom_range(0, 7) == 0);
      txn(1'($urandom_range(0, 1)), ra, $urandom);
    end
    timer_int = 1'b0;
    @(negedge CLK);

`ifdef TIMER_MMIO_INT_STATUS_EN
    txn(1'b1, A_CTL, 32'h3);
    timer_int = 1'b1;
    @(negedge CLK);
    timer_int = 1'b0;
    m_sts = 1'b1;
    repeat (2) begin @(negedge CLK); chk("irq_sticky", 64'(irq), 64'(1)); end
    txn(1'b0, A_STS, 32'h0);
    chk("status_read", 64'(x_rdata), 64'(1));
    txn(1'b1, A_STS, 32'h1);
    chk("irq_clear_next_cycle", 64'(x_irq1), 64'(0));
    timer_int = 1'b1;
    txn(1'b1, A_STS, 32'h1);
    chk("set_beats_clear", 64'(irq), 64'(1));
    timer_int = 1'b0;
    @(negedge CLK);
`else
    timer_int = 1'b1;
    #1 chk("irq_pass_hi", 64'(irq), 64'(1));
    timer_int = 1'b0;
    #1 chk("irq_pass_lo", 64'(irq), 64'(0));
    txn(1'b0, A_STS, 32'h0);
    txn(1'b1, A_CTL, 32'h3);
    txn(1'b0, A_CTL, 32'h0);
    chk("ctrl_ie_ignored", 64'(x_rdata), 64'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_mmio_ctrl.md
Name: timer_mmio_ctrl

Overview:
- Bus-side initiator for the Timer peripheral.
- Decodes single-word CPU load/store requests into Timer register accesses. Writes drive the Timer's level write strobes with a pulse-then-gap sequence so that the Timer's rising-edge detectors register exactly one commit per store.
- Returns mtime to the CPU as an atomic 64-bit pair via a high-word snapshot.
- Sits between the peripheral bus decoder and Timer.

Parameters:
- PULSE_CYCLES, 1: cycles a write strobe is held high; legal range is 1 or more.
- GAP_CYCLES, 2: cycles the strobe is held low before ack; legal range is 1 or more, which guarantees the commit lands before ack.
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF: reset value of the mtimecmp shadow.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- bus_req  in  1  request valid; held with addr/we/wdata until bus_ack
- bus_we  in  1  1=store, 0=load
- bus_addr  in  5  byte offset, word aligned: 0x00 mtime_l RO, 0x04 mtime_h RO, 0x08 mtimecmp_l, 0x0C mtimecmp_h, 0x10 ctrl (bit0=en)
- bus_wdata  in  32  store data
- bus_rdata  out  32  load data, valid with bus_ack
- bus_ack  out  1  one-cycle completion pulse
- mtime_h  in  32  from Timer
- mtime_l  in  32  from Timer
- timer_int  in  1  from Timer
- en  out  1  to Timer en
- wr_en  out  1  to Timer wr_en
- wr_mtimecmp_in_h  out  1  to Timer
- wr_mtimecmp_in_l  out  1  to Timer
- mtimecmp_in_h  out  32  shadow high word
- mtimecmp_in_l  out  32  shadow low word
- irq  out  1  interrupt to core

Behaviour:
- Clock and reset: one clock, CLK; reset RST_N is asynchronous and active-low.
- Reset values:
  - FSM goes to IDLE.
  - All strobes, bus_ack and en are 0; bus_rdata is 0.
  - {mtimecmp_in_h, mtimecmp_in_l} = CMP_RESET.
  - hi_snap = 0.
- Reset mid-transaction: the FSM aborts immediately, strobes drop, and no ack is issued. The bus master must reissue the request.
- FSM states: IDLE, STROBE, GAP, ACK.
- IDLE:
  - Requests are accepted only in IDLE, on a cycle where bus_req=1.
  - A store to 0x08, 0x0C or 0x10 updates the matching shadow (ctrl: en <= wdata[0]) at the accept edge, selects that strobe, and goes to STROBE.
  - All other requests go directly to ACK: loads, stores to RO or unmapped offsets, and misaligned offsets (bus_addr[1:0]!=0).
- STROBE: the selected strobe is high for PULSE_CYCLES cycles, then the FSM goes to GAP.
- GAP: all strobes are low for GAP_CYCLES cycles, then the FSM goes to ACK.
- ACK: bus_ack=1 for exactly one cycle, then the FSM returns to IDLE.
  - A bus_req still high in the next IDLE cycle is a new request; the master drops req the cycle after ack.
- Latency:
  - Mapped store: accept edge to ack is 1+PULSE_CYCLES+GAP_CYCLES cycles (4 at defaults).
  - Load, ignored store or unmapped access: ack in the cycle after accept.
- Only one strobe is ever high at a time. Shadow values and en are stable from the accept edge onward, so the Timer always captures settled data.
- Load data, registered at the accept edge:
  - 0x00 returns live mtime_l and simultaneously captures mtime_h into hi_snap.
  - 0x04 returns hi_snap.
  - 0x08, 0x0C, 0x10 return the shadows ({31'b0,en} for ctrl).
  - Unmapped offsets return 0.
  - Any ignored store returns rdata 0.
- Non-mapped accesses produce no strobe and raise no error.
- irq equals timer_int (combinational passthrough) when the optional feature below is not compiled in.

Optional Feature:
- Macro: TIMER_MMIO_INT_STATUS_EN.
- Defined:
  - A sticky status bit is set on any cycle where timer_int=1 and cleared to 0 at reset.
  - It is readable at 0x14 as bit0.
  - A store to 0x14 with wdata[0]=1 clears it at the accept edge (write-1-to-clear); a set in the same cycle wins over the clear.
  - irq is driven by the sticky bit and ctrl bit1 (irq enable, reset 0); the ctrl load returns {30'b0,ie,en}.
  - 0x14 accesses ack in one cycle.
- Undefined: 0x14 is unmapped, ctrl bit1 is ignored and reads 0, and irq = timer_int.

Decomposition:
- Package timer_mmio_pkg:
  - address offset localparams (ADDR_MTIME_L, ADDR_MTIME_H, ADDR_CMP_L, ADDR_CMP_H, ADDR_CTRL, ADDR_STATUS);
  - FSM state enum;
  - strobe-select enum (SEL_NONE/SEL_EN/SEL_CMP_L/SEL_CMP_H).
- One sub-module, timer_strobe_seq, holds the STROBE/GAP counter and the single strobe output. Its interface is start, sel, strobe vector and done.
- The top level keeps bus decode, shadows, hi_snap and read mux.

Test Plan:
- Store 0xDEAD_BEEF to 0x08 after reset: wr_mtimecmp_in_l is high for exactly 1 cycle, mtimecmp_in_l=0xDEADBEEF, bus_ack comes 4 cycles after accept, and the Timer's mtimecmp low word equals 0xDEADBEEF before ack.
- Back-to-back stores 0x1 to 0x10, then 0x0 to 0x10: two separate wr_en pulses each followed by 2 low cycles, and the Timer en goes 1 then 0.
- With mtime_h=0x0000_0001 and mtime_l=0xFFFF_FFFF presented, load 0x00, then change mtime_h to 0x2 before loading 0x04: rdata returns 0xFFFF_FFFF then 0x0000_0001.
- Store to 0x00 and load from 0x18: no strobe toggles, ack in 1 cycle, rdata=0, all shadows unchanged.
- Assert RST_N=0 during STROBE of a 0x0C store: strobe drops asynchronously, no ack, and the shadow reads back 0xFFFF_FFFF after reset.
- With TIMER_MMIO_INT_STATUS_EN, pulse timer_int 1 cycle with ctrl=0x3:
  - irq stays 1 and a load of 0x14 returns 0x1;
  - a store of 0x1 to 0x14 clears irq on the cycle after the accept edge.
